// File: rtl/fifo_port_scheduler.sv
// Paces one shared BRAM FIFO and round-robins its read port over NUM_REQ
// requesters. Ports: clk/rst_n, wr_valid/wr_ready/wr_data producer side,
// req/rsp_valid/rsp_data consumer side, count/empty/full occupancy,
// underrun_count stats, fifo_rst/fifo_wr/fifo_din/fifo_rd/fifo_dout to
// the FIFO. Define FIFO_SCHED_STATS_EN to build the underrun counter.
module fifo_port_scheduler #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 512,
  parameter int NUM_REQ = 4,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [CW-1:0]      count,
  output logic               empty,
  output logic               full,
  output logic [15:0]        underrun_count,
  output logic               fifo_rst,
  output logic               fifo_wr,
  output logic [WIDTH-1:0]   fifo_din,
  output logic               fifo_rd,
  input  logic [WIDTH-1:0]   fifo_dout
);

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_PULSE   = 2'd1;
  localparam logic [1:0] W_GAP     = 2'd2;

  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_ISSUE   = 2'd1;
  localparam logic [1:0] R_WAIT    = 2'd2;
  localparam logic [1:0] R_CAPTURE = 2'd3;

  logic [1:0]    rst_sync;
  logic [1:0]    wstate;
  logic [1:0]    rstate;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic          pick_ok;
  logic [GW:0]   cand;
  logic          inc;
  logic          dec;

  // FIFO reset asserts at once, releases two edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b11;
    else        rst_sync <= {rst_sync[0], 1'b0};
  end

  assign fifo_rst = rst_sync[1];

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign wr_ready = (wstate == W_IDLE) && !full && !fifo_rst;
  assign fifo_wr  = (wstate == W_PULSE);
  assign fifo_rd  = (rstate == R_ISSUE);
  assign inc      = fifo_wr;
  assign dec      = fifo_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate   <= W_IDLE;
      fifo_din <= '0;
    end else if (fifo_rst) begin
      wstate   <= W_IDLE;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (wr_valid && wr_ready) begin
            fifo_din <= wr_data;
            wstate   <= W_PULSE;
          end
        end
        W_PULSE: wstate <= W_GAP;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Round-robin search starting one past the last grant
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_REQ))
        cand = cand - (GW+1)'(NUM_REQ);
      if (!pick_ok && req[cand[GW-1:0]]) begin
        pick    = cand[GW-1:0];
        pick_ok = 1'b1;
      end
    end
  end

  // No grant in the response cycle: the answered requester
  // may still be holding req there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate    <= R_IDLE;
      rr_ptr    <= GW'(NUM_REQ - 1);
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (fifo_rst) begin
      rstate    <= R_IDLE;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (rstate)
        R_IDLE: begin
          if (!(|rsp_valid) && !empty && pick_ok) begin
            rr_ptr <= pick;
            rstate <= R_ISSUE;
          end
        end
        R_ISSUE: rstate <= R_WAIT;
        R_WAIT:  rstate <= R_CAPTURE;
        default: begin
          rsp_data  <= fifo_dout;
          rsp_valid <= NUM_REQ'(1) << rr_ptr;
          rstate    <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (fifo_rst)      count <= '0;
    else if (inc && !dec)   count <= count + CW'(1);
    else if (dec && !inc)   count <= count - CW'(1);
  end

`ifdef FIFO_SCHED_STATS_EN
  logic [15:0] urun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urun_q <= '0;
    end else if (!fifo_rst && rstate == R_IDLE
                 && |req && empty
                 && urun_q != 16'hFFFF) begin
      urun_q <= urun_q + 16'd1;
    end
  end

  assign underrun_count = urun_q;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: doc/fifo_port_scheduler.md
# fifo_port_scheduler

Controller that owns one shared BRAM sample FIFO (pulse-edge `rd`/`wr`, 2-cycle read latency, no status flags) and shares its read port among several track consumers. It paces FIFO write and read pulses, tracks occupancy so the FIFO never overflows or underflows, grants reads round-robin, and routes each returned sample to the requester that asked for it. It sits between the recording/loading path (producer) and the per-track playback mixers (consumers).

## Interface
- `WIDTH`, 16, sample width in bits.
- `DEPTH`, 512, FIFO depth in entries; must match the attached FIFO.
- `NUM_REQ`, 4, number of read requesters, 2..8.

- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `wr_valid` in 1: producer has a sample.
- `wr_ready` out 1: sample accepted on a cycle where `wr_valid && wr_ready`.
- `wr_data` in WIDTH: producer sample.
- `req` in NUM_REQ: per-requester level read request.
- `rsp_valid` out NUM_REQ: one-cycle pulse to the granted requester.
- `rsp_data` out WIDTH: returned sample; valid only with a `rsp_valid` bit.
- `count` out clog2(DEPTH+1): current occupancy.
- `empty`, `full` out 1: `count==0`, `count==DEPTH`.
- `underrun_count` out 16: see Configuration.
- `fifo_rst` out 1: active-high synchronous reset to the FIFO.
- `fifo_wr` out 1 / `fifo_din` out WIDTH: FIFO write side.
- `fifo_rd` out 1 / `fifo_dout` in WIDTH: FIFO read side.

## Operation
- Reset bridge: `fifo_rst` goes high asynchronously on `rst_n` low and drops 2 `clk` edges after `rst_n` rises. While `fifo_rst`=1, all FSMs are held in their idle state and `wr_ready`=0.
- Write FSM (W_IDLE, W_PULSE, W_GAP): W_IDLE has `wr_ready`=`!full && !fifo_rst`. On accept, latch `wr_data` into `fifo_din` and go to W_PULSE (`fifo_wr`=1), then W_GAP (`fifo_wr`=0), then W_IDLE. Maximum rate is 1 write per 3 cycles. The low gap is mandatory because the FIFO acts on rising edges of `wr`.
- Read FSM (R_IDLE, R_ISSUE, R_WAIT, R_CAPTURE):
  - R_IDLE: if `count>0` and any `req` bit is set, pick the grant round-robin, starting the search at last grant+1 mod NUM_REQ, and go to R_ISSUE.
  - R_ISSUE: `fifo_rd`=1.
  - R_WAIT: `fifo_rd`=0.
  - R_CAPTURE: register `fifo_dout` (2 cycles after the `fifo_rd` rise) into `rsp_data`. The next cycle pulses `rsp_valid[grant]` and returns to R_IDLE.
- Requesters hold `req` until their `rsp_valid`. Dropping `req` before grant withdraws it. A granted transaction always completes.
- Occupancy: `count` +1 at the end of W_PULSE and −1 at the end of R_ISSUE. When both happen in the same cycle, `count` is unchanged. `count` never wraps. The pointer wrap at DEPTH is the FIFO's responsibility.
- An R_ISSUE never starts in the same cycle that `count` becomes nonzero. It starts earliest in the cycle after the increment.

## Timing
- Reset values: `wr_ready`=0, `rsp_valid`=0, `rsp_data`=0, `fifo_rd`=0, `fifo_wr`=0, `fifo_din`=0, `count`=0, `empty`=1, `full`=0, `underrun_count`=0, `fifo_rst`=1, round-robin pointer = NUM_REQ−1 (so requester 0 wins first).
- Read latency: from a `req` seen in R_IDLE to `rsp_valid` is 4 cycles. Minimum spacing between grants is 5 cycles.
- If `rst_n` is asserted mid-transaction, the transaction is aborted. No `rsp_valid` is emitted, `count` clears, and the FIFO is reset with it.
- Full: `wr_ready`=0 until a read completes R_ISSUE. Empty: requests wait in R_IDLE and no `fifo_rd` is issued.

## Configuration
- `FIFO_SCHED_STATS_EN` defined: `underrun_count` increments once per cycle in which the Read FSM is in R_IDLE, some `req` bit is set, and `count==0`. It saturates at 16'hFFFF and clears only on reset.
- Not defined: `underrun_count` is tied to 0 and the counter logic is absent.

## Test plan
- Reset: hold `rst_n`=0, release → `fifo_rst` falls exactly 2 edges later; every output equals its reset value until then.
- Write 3 samples 0x0011, 0x0022, 0x0033 back-to-back with `wr_valid`=1 → `fifo_wr` pulses spaced 3 cycles apart, `count` reaches 3, and `wr_ready` is low in W_PULSE/W_GAP.
- With `count`=3, assert `req`=4'b1111 continuously → grants go to 0, 1, 2 in order, `rsp_data`=0x0011, 0x0022, 0x0033, each `rsp_valid` arrives 4 cycles after its grant, and `count` ends at 0.
- Fill to DEPTH=512 → `full`=1 and `wr_ready`=0. A single read → `count`=511 and `wr_ready` returns in the following cycle. A simultaneous write and read leaves `count` unchanged.
- With `FIFO_SCHED_STATS_EN` defined and `count`=0, hold `req[2]`=1 for 10 cycles → `underrun_count`=10. A subsequent write → requester 2 receives the sample and the counter stops incrementing.
- Assert `rst_n`=0 in R_WAIT → no `rsp_valid` is emitted, `count`=0, and `fifo_rst`=1 immediately.
